// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive path (and its transmitter
// counterpart).
//   uart_state_t : frame FSM state. The 2-bit encoding is identical on both
//                  sides, so state values read the same in either waveform.
//   *_LEVEL      : line levels for idle, start bit and stop bit.
//   cnt_width()  : counter width for a given modulus. The result is never
//                  less than 1 bit.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Width needed to count 0..n-1. A modulus of 1 still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input bit.
// The RESET_VALUE parameter sets the output level during reset. For the
// serial line this is the idle level, so coming out of reset never looks
// like a start bit.
// Ports:
//   clk : system clock, posedge
//   rst : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronised output, delayed by 2 clk cycles
// -----------------------------------------------------------------------------
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VALUE = IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VALUE;
      sync_reg <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// UART receive path for 8N1-style frames: 1 start bit (0), then DATA_BITS
// data bits sent LSB first, then 1 stop bit (1). The line idles high.
// The input is oversampled. Counting advances only on cycles where the
// rxclken tick is high, and rxclken runs at OVERSAMPLE x the baud rate.
// Parameters:
//   OVERSAMPLE : rxclken ticks per bit period (must be even and >= 4)
//   DATA_BITS  : data bits per frame
// Ports:
//   rxclk     : system clock, posedge
//   rst       : synchronous, active-high reset
//   rx        : serial line (asynchronous, idles high)
//   rxclken   : oversample tick, a 1-cycle pulse
//   rdy_clr   : consumer acknowledge; clears rdy and overrun
//   dout      : last byte received with a good stop bit
//   rdy       : a new byte is available (sticky)
//   rx_busy   : high whenever the FSM is not in IDLE
//   frame_err : the last frame had a stop bit of 0 (sticky)
//   overrun   : a byte arrived while rdy was still high (sticky)
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 rxclk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rxclken,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W = cnt_width(DATA_BITS);

  // START waits half a bit so that each later sample lands mid-bit.
  // DATA and STOP then wait one whole bit between samples.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(
    .RESET_VALUE(IDLE_LEVEL)
  ) u_sync (
    .clk (rxclk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_t           state_reg,     state_next;
  logic [CNT_W-1:0]      sample_cnt_reg, sample_cnt_next;
  logic [BIT_W-1:0]      bitpos_reg,    bitpos_next;
  logic [DATA_BITS-1:0]  shift_reg,     shift_next;
  logic                  armed_reg,     armed_next;
  logic [DATA_BITS-1:0]  dout_reg,      dout_next;
  logic                  rdy_reg,       rdy_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  overrun_reg,   overrun_next;
  logic                  load;

  // State register
  always_ff @(posedge rxclk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= '0;
      bitpos_reg     <= '0;
      shift_reg      <= '0;
      armed_reg      <= 1'b0;
      dout_reg       <= '0;
      rdy_reg        <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      bitpos_reg     <= bitpos_next;
      shift_reg      <= shift_next;
      armed_reg      <= armed_next;
      dout_reg       <= dout_next;
      rdy_reg        <= rdy_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next      = state_reg;
    sample_cnt_next = sample_cnt_reg;
    bitpos_next     = bitpos_reg;
    shift_next      = shift_reg;
    armed_next      = armed_reg;
    dout_next       = dout_reg;
    rdy_next        = rdy_reg;
    frame_err_next  = frame_err_reg;
    overrun_next    = overrun_reg;
    load            = 1'b0;

    if (rxclken) begin
      unique case (state_reg)
        IDLE: begin
          // A start bit is accepted only after the line has been seen high
          // at least once. This stops a held-low line from retriggering.
          if (rx_s == IDLE_LEVEL) begin
            armed_next = 1'b1;
          end else if (armed_reg) begin
            state_next      = START;
            sample_cnt_next = '0;
            frame_err_next  = 1'b0;
          end
        end

        START: begin
          if (sample_cnt_reg == CNT_HALF) begin
            if (rx_s == START_LEVEL) begin
              state_next      = DATA;
              sample_cnt_next = '0;
              bitpos_next     = '0;
            end else begin
              // Line went high again before mid-bit: treat it as a glitch.
              state_next = IDLE;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (sample_cnt_reg == CNT_FULL) begin
            shift_next[bitpos_reg] = rx_s;
            sample_cnt_next        = '0;
            if (bitpos_reg == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bitpos_next = bitpos_reg + BIT_W'(1);
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          if (sample_cnt_reg == CNT_FULL) begin
            state_next      = IDLE;
            sample_cnt_next = '0;
            if (rx_s == STOP_LEVEL) begin
              load       = 1'b1;
              armed_next = 1'b1;
            end else begin
              // Break or framing error: flag it once, then wait for the
              // line to return high before accepting another start bit.
              frame_err_next = 1'b1;
              armed_next     = 1'b0;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + CNT_W'(1);
          end
        end

        default: state_next = IDLE;
      endcase
    end

    if (rdy_clr) begin
      rdy_next     = 1'b0;
      overrun_next = 1'b0;
    end

    // A new byte takes priority over an acknowledge in the same cycle.
    // The acknowledge still cancels the overrun, because the previous byte
    // has been consumed.
    if (load) begin
      dout_next = shift_reg;
      rdy_next  = 1'b1;
      if (rdy_reg && !rdy_clr) begin
        overrun_next = 1'b1;
      end
    end
  end

  assign dout      = dout_reg;
  assign rdy       = rdy_reg;
  assign rx_busy   = (state_reg != IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed testbench for uart_receiver with OVERSAMPLE=16 and DATA_BITS=8.
// Inputs are driven on the falling edge of the clock, and outputs are sampled
// on the same falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          rxclk   = 1'b0;
  logic          rst     = 1'b1;
  logic          rx      = 1'b1;
  logic          rxclken = 1'b1;
  logic          rdy_clr = 1'b0;
  logic [DB-1:0] dout;
  logic          rdy;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  int   rise_cyc = -1;
  int   cyc_cnt  = 0;
  logic prev_rdy = 1'b0;
  int   tick_div = 1;
  int   tick_ph  = 0;

  uart_receiver #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .rxclk    (rxclk),
    .rst      (rst),
    .rx       (rx),
    .rxclken  (rxclken),
    .rdy_clr  (rdy_clr),
    .dout     (dout),
    .rdy      (rdy),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 rxclk = ~rxclk;

  // Oversample tick: high every cycle, or high on every 3rd cycle.
  always @(negedge rxclk) begin
    if (tick_div == 1) begin
      rxclken = 1'b1;
    end else begin
      rxclken = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % 3;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of the line, then record busy cycles and when rdy rises.
  task automatic step(input logic level, input int clr_at);
    rx      = level;
    rdy_clr = (clr_at >= 0) && (cyc_cnt == clr_at);
    @(negedge rxclk);
    if (rx_busy) busy_cnt++;
    if (!prev_rdy && rdy && rise_cyc < 0) rise_cyc = cyc_cnt;
    prev_rdy = rdy;
    cyc_cnt++;
  endtask

  task automatic hold(input logic level, input int n);
    for (int i = 0; i < n; i++) step(level, -1);
    rdy_clr = 1'b0;
  endtask

  // Send one frame. clr_at pulses rdy_clr on the given cycle of the frame,
  // and max_cyc cuts the frame short after that many cycles.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit,
                            input int bitlen, input int clr_at, input int max_cyc);
    logic [DB+1:0] f;
    f        = {stop_bit, data, 1'b0};
    cyc_cnt  = 0;
    busy_cnt = 0;
    rise_cyc = -1;
    prev_rdy = rdy;
    for (int c = 0; c < (DB + 2) * bitlen; c++) begin
      if (c >= max_cyc) break;
      step(f[c / bitlen], clr_at);
    end
    rdy_clr = 1'b0;
    $display("frame data=0x%02h stop=%0d bitlen=%0d -> dout=0x%02h rdy=%0d ferr=%0d ovr=%0d",
             data, stop_bit, bitlen, dout, rdy, frame_err, overrun);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(negedge rxclk);
    rdy_clr = 1'b0;
  endtask

  initial begin
    // ---- Reset state ----
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge rxclk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    hold(1'b1, 20);

    // ---- 1: good frame 0xA5 ----
    // Busy lasts half a bit of START, 8 bits of DATA and 1 bit of STOP:
    // 8 + 128 + 16 = 152 cycles. rdy rises on frame cycle 154, which is
    // the 2-cycle synchroniser delay plus 8 + 128 + 16.
    send_frame(8'hA5, 1'b1, OS, -1, 1000);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd152);
    check("t1_rdy_rise_cyc", 32'(rise_cyc), 32'd154);
    check("t1_dout", 32'(dout), 32'hA5);
    check("t1_rdy", 32'(rdy), 32'd1);
    check("t1_ferr", 32'(frame_err), 32'd0);
    check("t1_ovr", 32'(overrun), 32'd0);
    check("t1_busy_end", 32'(rx_busy), 32'd0);
    pulse_clr();
    check("t1_rdy_cleared", 32'(rdy), 32'd0);

    // ---- 2: 4-tick glitch on the line ----
    hold(1'b1, 16);
    busy_cnt = 0;
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd8);
    check("t2_busy", 32'(rx_busy), 32'd0);
    check("t2_rdy", 32'(rdy), 32'd0);
    check("t2_ferr", 32'(frame_err), 32'd0);
    check("t2_dout", 32'(dout), 32'hA5);

    // ---- 3: stop bit 0 followed by a 40-bit break ----
    send_frame(8'h3C, 1'b0, OS, -1, 1000);
    hold(1'b0, 40 * OS);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd152);
    check("t3_ferr", 32'(frame_err), 32'd1);
    check("t3_rdy", 32'(rdy), 32'd0);
    check("t3_dout", 32'(dout), 32'hA5);
    check("t3_busy", 32'(rx_busy), 32'd0);
    hold(1'b1, 2 * OS);
    send_frame(8'h55, 1'b1, OS, -1, 1000);
    check("t3_dout_55", 32'(dout), 32'h55);
    check("t3_rdy_55", 32'(rdy), 32'd1);
    check("t3_ferr_55", 32'(frame_err), 32'd0);

    // ---- 4: overrun, and an acknowledge on the same cycle as a load ----
    pulse_clr();
    hold(1'b1, OS);
    send_frame(8'h11, 1'b1, OS, -1, 1000);
    check("t4_dout_11", 32'(dout), 32'h11);
    send_frame(8'h22, 1'b1, OS, -1, 1000);
    check("t4_dout_22", 32'(dout), 32'h22);
    check("t4_rdy", 32'(rdy), 32'd1);
    check("t4_ovr", 32'(overrun), 32'd1);
    pulse_clr();
    check("t4_ovr_cleared", 32'(overrun), 32'd0);
    check("t4_rdy_cleared", 32'(rdy), 32'd0);
    send_frame(8'h11, 1'b1, OS, -1, 1000);
    check("t4_rdy_11b", 32'(rdy), 32'd1);
    send_frame(8'h22, 1'b1, OS, 154, 1000);
    check("t4_clr_load_dout", 32'(dout), 32'h22);
    check("t4_clr_load_rdy", 32'(rdy), 32'd1);
    check("t4_clr_load_ovr", 32'(overrun), 32'd0);

    // ---- 5: tick on every 3rd cycle (48-cycle bits), with a reset mid-frame ----
    pulse_clr();
    tick_div = 3;
    hold(1'b1, 3 * OS);
    send_frame(8'hF0, 1'b1, 3 * OS, -1, 100000);
    hold(1'b1, 3 * OS);
    check("t5_dout_f0", 32'(dout), 32'hF0);
    check("t5_rdy_f0", 32'(rdy), 32'd1);
    check("t5_ovr_f0", 32'(overrun), 32'd0);
    // Stop in the middle of data bit 4, which is frame bit index 5.
    send_frame(8'h5A, 1'b1, 3 * OS, -1, 5 * 3 * OS + 24);
    check("t5_busy_before_rst", 32'(rx_busy), 32'd1);
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge rxclk);
    rst = 1'b0;
    check("t5_rst_dout", 32'(dout), 32'h00);
    check("t5_rst_rdy", 32'(rdy), 32'd0);
    check("t5_rst_busy", 32'(rx_busy), 32'd0);
    check("t5_rst_ferr", 32'(frame_err), 32'd0);
    check("t5_rst_ovr", 32'(overrun), 32'd0);
    hold(1'b1, 2 * 3 * OS);
    send_frame(8'h81, 1'b1, 3 * OS, -1, 100000);
    hold(1'b1, 3 * OS);
    check("t5_dout_81", 32'(dout), 32'h81);
    check("t5_rdy_81", 32'(rdy), 32'd1);
    check("t5_ferr_81", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
